// File: rtl/im_prefetch_if.sv
// Bundle of load, redirect and decode-side signals for the instruction prefetcher.
// master = the side that loads programs, redirects and consumes; slave = the prefetcher.
interface im_prefetch_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [31:0]       out_pc;
    logic [31:0]       out;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        sa;
    logic [5:0]        func;
    logic [15:0]       imm_or_offset;
    logic [25:0]       adr;
    logic [CW-1:0]     fifo_count;

    modport master (
        output load_en, load_addr, load_data, redirect, redirect_pc, out_ready,
        input  out_valid, out_pc, out, op, rs, rt, rd, sa, func, imm_or_offset, adr,
               fifo_count
    );

    modport slave (
        input  load_en, load_addr, load_data, redirect, redirect_pc, out_ready,
        output out_valid, out_pc, out, op, rs, rt, rd, sa, func, imm_or_offset, adr,
               fifo_count
    );
endinterface

// File: rtl/im_prefetch.sv
// Loadable program memory with a sequential fetch PC feeding a small prefetch FIFO;
// the head entry is presented with its decoded fields over valid/ready.
module im_prefetch #(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    im_prefetch_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] fifo_pc_q   [DEPTH];
    logic [31:0] fifo_word_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic              issue;
    logic              pop;
    logic              head_valid;
    logic              out_of_range;
    logic [ADDR_W-1:0] fetch_idx;
    logic [31:0]       fetch_word;
    logic [31:0]       head_word;

    assign fetch_idx    = fetch_pc_q[ADDR_W+1:2];
    // Any PC bit above the memory span selects nothing: such fetches return zero (NOP).
    assign out_of_range = (fetch_pc_q >> (ADDR_W + 2)) != 32'd0;
    assign fetch_word   = out_of_range ? 32'd0 : mem[fetch_idx];

    assign head_valid = (count_q != '0);
    assign pop        = head_valid && bus.out_ready;
    // Occupancy is taken before any same-cycle pop, so a full FIFO never issues.
    assign issue      = !rst && !bus.redirect && !bus.load_en && (count_q < CW'(DEPTH));

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (issue) begin
                tail_d     = tail_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (issue && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!issue && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Program memory survives reset, so loads are honoured even while rst is high.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_pc_q[tail_q]   <= fetch_pc_q;
            fifo_word_q[tail_q] <= fetch_word;
        end
    end

    assign head_word = head_valid ? fifo_word_q[head_q] : 32'd0;

    assign bus.out_valid     = head_valid;
    assign bus.out_pc        = head_valid ? fifo_pc_q[head_q] : 32'd0;
    assign bus.out           = head_word;
    assign bus.op            = head_word[31:26];
    assign bus.rs            = head_word[25:21];
    assign bus.rt            = head_word[20:16];
    assign bus.rd            = head_word[15:11];
    assign bus.sa            = head_word[10:6];
    assign bus.func          = head_word[5:0];
    assign bus.imm_or_offset = head_word[15:0];
    assign bus.adr           = head_word[25:0];
    assign bus.fifo_count    = count_q;
endmodule

// File: tb/tb_im_prefetch.sv
// Self-checking bench for im_prefetch: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_im_prefetch;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    im_prefetch_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    im_prefetch #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: program memory, fetch PC and a queue of {pc, word}.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    logic [31:0] mmem [2**AW];
    logic [31:0] mpc = 32'h0;
    ent_t        mq[$];
    bit          m_iss;
    bit          m_pop;

    function automatic logic [31:0] mword(input logic [31:0] pc);
        if ((pc >> (AW + 2)) != 32'd0) return 32'd0;
        return mmem[pc[AW+1:2]];
    endfunction

    always @(posedge clk) begin
        m_iss = !rst && !bus.redirect && !bus.load_en && (mq.size() < DEPTH);
        m_pop = (mq.size() != 0) && bus.out_ready;
        if (rst) begin
            mq.delete();
            mpc = 32'h0;
        end else if (bus.redirect) begin
            mq.delete();
            mpc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_iss) begin
                mq.push_back('{pc: mpc, word: mword(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        if (bus.load_en) mmem[bus.load_addr] = bus.load_data;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] w;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2**AW; i++) begin
            case (i)
                0:       w = 32'h2010_0000;
                1:       w = 32'h2011_0000;
                2:       w = 32'h0211_402a;
                default: w = $urandom;
            endcase
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(i);
            bus.load_data = w;
            tick();
        end
        bus.load_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0 || bus.out !== 32'd0 || bus.out_pc !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b count=%0d out=%h pc=%h, want 0/0/0/0",
                     bus.out_valid, bus.fifo_count, bus.out, bus.out_pc);
        end
        $display("reset: valid=%b count=%0d", bus.out_valid, bus.fifo_count);
    endtask

    task automatic test_stream_decode;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_w  [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_w  = '{32'h2010_0000, 32'h2011_0000, 32'h0211_402a};
        idle_inputs();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_release: valid=%b want 0", bus.out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[k] || bus.out !== exp_w[k]) begin
                n_bad++;
                $display("FAIL stream_pc%0d: valid=%b pc=%h out=%h want 1/%h/%h",
                         k, bus.out_valid, bus.out_pc, bus.out, exp_pc[k], exp_w[k]);
            end
            $display("stream: pc=%h out=%h", bus.out_pc, bus.out);
        end
        n_cmp++;
        if (bus.op !== 6'd0 || bus.rs !== 5'd16 || bus.rt !== 5'd17 || bus.rd !== 5'd8 ||
            bus.sa !== 5'd0 || bus.func !== 6'h2a || bus.imm_or_offset !== 16'h402a ||
            bus.adr !== 26'h211402a) begin
            n_bad++;
            $display("FAIL decode_fields: op=%0d rs=%0d rt=%0d rd=%0d sa=%0d func=%h imm=%h adr=%h want 0/16/17/8/0/2a/402a/211402a",
                     bus.op, bus.rs, bus.rt, bus.rd, bus.sa, bus.func, bus.imm_or_offset, bus.adr);
        end
    endtask

    task automatic test_backpressure;
        int exp_cnt;
        idle_inputs();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_cnt = (k < DEPTH) ? k : DEPTH;
            n_cmp++;
            if (bus.fifo_count !== 3'(exp_cnt)) begin
                n_bad++;
                $display("FAIL backpressure_count: count=%0d want %0d", bus.fifo_count, exp_cnt);
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) || bus.out !== mmem[k]) begin
                n_bad++;
                $display("FAIL backpressure_order: valid=%b pc=%h out=%h want 1/%h/%h",
                         bus.out_valid, bus.out_pc, bus.out, 32'(4 * k), mmem[k]);
            end
            $display("backpressure: pc=%h count=%0d", bus.out_pc, bus.fifo_count);
            tick();
        end
    endtask

    task automatic test_redirect;
        idle_inputs();
        do_reset();
        repeat (3) tick();
        n_cmp++;
        if (bus.fifo_count !== 3'd3) begin
            n_bad++;
            $display("FAIL redirect_prefill: count=%0d want 3", bus.fifo_count);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h13;
        bus.out_ready   = 1'b1;
        tick();
        bus.redirect = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL redirect_flush: valid=%b count=%0d want 0/0", bus.out_valid, bus.fifo_count);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h10 || bus.out !== mmem[4]) begin
            n_bad++;
            $display("FAIL redirect_target: valid=%b pc=%h out=%h want 1/10/%h",
                     bus.out_valid, bus.out_pc, bus.out, mmem[4]);
        end
        $display("redirect: pc=%h out=%h", bus.out_pc, bus.out);
    endtask

    task automatic test_out_of_range;
        idle_inputs();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h400;
        tick();
        bus.redirect = 1'b0;
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'd0 || bus.out_pc !== 32'h400 ||
            {bus.op, bus.rs, bus.rt, bus.rd, bus.sa, bus.func, bus.imm_or_offset, bus.adr} !== '0) begin
            n_bad++;
            $display("FAIL out_of_range: valid=%b pc=%h out=%h op=%0d adr=%h want 1/400/0/0/0",
                     bus.out_valid, bus.out_pc, bus.out, bus.op, bus.adr);
        end
        $display("out_of_range: pc=%h out=%h", bus.out_pc, bus.out);
    endtask

    task automatic test_load_priority;
        idle_inputs();
        do_reset();
        tick();
        bus.load_en   = 1'b1;
        bus.load_addr = 8'd1;
        bus.load_data = 32'hac12_0040;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (bus.fifo_count !== 3'd1) begin
                n_bad++;
                $display("FAIL load_no_issue: count=%0d want 1", bus.fifo_count);
            end
        end
        bus.load_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.fifo_count !== 3'd2) begin
            n_bad++;
            $display("FAIL load_resume: count=%0d want 2", bus.fifo_count);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.out_pc !== 32'h4 || bus.out !== 32'hac12_0040) begin
            n_bad++;
            $display("FAIL load_word: pc=%h out=%h want 4/ac120040", bus.out_pc, bus.out);
        end
        $display("load_priority: pc=%h out=%h", bus.out_pc, bus.out);
    endtask

    task automatic test_reset_midstream;
        idle_inputs();
        do_reset();
        repeat (5) tick();
        n_cmp++;
        if (bus.fifo_count !== 3'd4) begin
            n_bad++;
            $display("FAIL midreset_full: count=%0d want 4", bus.fifo_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL midreset_clear: valid=%b count=%0d want 0/0", bus.out_valid, bus.fifo_count);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out !== 32'h2010_0000) begin
            n_bad++;
            $display("FAIL midreset_refetch: valid=%b pc=%h out=%h want 1/0/20100000",
                     bus.out_valid, bus.out_pc, bus.out);
        end
        $display("reset_midstream: pc=%h out=%h", bus.out_pc, bus.out);
    endtask

    task automatic test_random;
        logic [31:0] ew;
        logic [31:0] epc;
        bit          ev;
        int          r;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            ev  = (mq.size() != 0);
            ew  = ev ? mq[0].word : 32'd0;
            epc = ev ? mq[0].pc : 32'd0;
            n_cmp++;
            if (bus.out_valid !== ev || bus.fifo_count !== 3'(mq.size()) ||
                bus.out_pc !== epc || bus.out !== ew) begin
                n_bad++;
                $display("FAIL random_head c=%0d: valid=%b count=%0d pc=%h out=%h want %b/%0d/%h/%h",
                         c, bus.out_valid, bus.fifo_count, bus.out_pc, bus.out,
                         ev, mq.size(), epc, ew);
            end
            n_cmp++;
            if ({bus.op, bus.rs, bus.rt, bus.rd, bus.sa, bus.func, bus.imm_or_offset, bus.adr} !==
                {ew[31:26], ew[25:21], ew[20:16], ew[15:11], ew[10:6], ew[5:0], ew[15:0], ew[25:0]}) begin
                n_bad++;
                $display("FAIL random_fields c=%0d: op=%h rs=%h rt=%h imm=%h adr=%h word=%h",
                         c, bus.op, bus.rs, bus.rt, bus.imm_or_offset, bus.adr, ew);
            end
            $display("random c=%0d: valid=%b pc=%h count=%0d", c, bus.out_valid, bus.out_pc, bus.fifo_count);
            rst           = ($urandom_range(0, 99) < 2);
            bus.redirect  = ($urandom_range(0, 99) < 8);
            r             = $urandom_range(0, 3);
            bus.redirect_pc = (r == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 32'h500));
            bus.load_en   = ($urandom_range(0, 99) < 10);
            bus.load_addr = AW'($urandom);
            bus.load_data = $urandom;
            bus.out_ready = ($urandom_range(0, 99) < 60);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_stream_decode();
        test_backpressure();
        test_redirect();
        test_out_of_range();
        test_load_priority();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
